// File: rtl/seg_pkg.sv
// Shared constants, digit-pointer type and anode decode for the 4-digit scanner.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef logic [1:0] digit_ptr_t;

    // Active-low one-hot anode pattern for the digit currently being driven.
    function automatic logic [NUM_DIGITS-1:0] ptr_to_an(input digit_ptr_t ptr);
        logic [NUM_DIGITS-1:0] onehot;
        onehot      = '0;
        onehot[ptr] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg_tick.sv
// Refresh prescaler: free-running 0..DIV-1 counter, tick high in the terminal count cycle.
module seg_tick #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    // Count up and wrap to zero on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with double-buffered digit load,
// leading-zero blanking and (when SEG_BLINK_EN is defined) per-digit blinking.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  number,
    output logic [3:0]  an,
    output logic        load_ack,
    output logic        frame_done
);

    logic        w_tick;
    logic        w_wrap;
    logic        w_apply;
    digit_ptr_t  r_ptr;
    digit_ptr_t  w_ptr_nxt;
    logic [15:0] r_pending;
    logic        r_pending_valid;
    logic [15:0] r_shadow;
    logic [15:0] w_shadow_nxt;
    logic [3:0]  w_zero;
    logic [3:0]  w_lz;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic        w_blink;
    logic [3:0]  w_number_nxt;
    logic [3:0]  r_an;
    logic [3:0]  r_number;
    logic        r_load_ack;
    logic        r_frame_done;

    seg_tick #(
        .DIV (REFRESH_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_wrap       = w_tick && (r_ptr == 2'(NUM_DIGITS - 1));
    assign w_apply      = w_wrap && r_pending_valid;
    assign w_ptr_nxt    = w_tick ? (r_ptr + 2'd1) : r_ptr;
    assign w_shadow_nxt = w_apply ? r_pending : r_shadow;

    // Leading-zero chain: digit i is a leading zero when it and every higher digit are zero.
    always_comb begin
        w_zero = 4'b0000;
        w_lz   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_zero[i] = (w_shadow_nxt[i*4 +: 4] == 4'h0);
        end
        w_lz[3] = w_zero[3];
        w_lz[2] = w_zero[2] & w_lz[3];
        w_lz[1] = w_zero[1] & w_lz[2];
        w_lz[0] = 1'b0;
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] r_frame_cnt;
    logic          r_phase;
    logic          w_frame_last;
    logic          w_phase_nxt;

    assign w_frame_last = (r_frame_cnt == FW'(BLINK_FRAMES - 1));
    assign w_phase_nxt  = (w_wrap && w_frame_last) ? ~r_phase : r_phase;
    assign w_blink      = w_phase_nxt & blink_mask[w_ptr_nxt];

    // Blink phase flips after every BLINK_FRAMES completed scan frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_wrap) begin
            if (w_frame_last) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end
`else
    localparam int unsigned UNUSED_BLINK_FRAMES = BLINK_FRAMES;

    logic w_unused_blink;

    assign w_unused_blink = &{1'b0, blink_mask};
    assign w_blink        = 1'b0;
`endif

    // Digit code for the slot being entered, computed from post-edge pointer and shadow.
    always_comb begin
        w_digit      = w_shadow_nxt[{w_ptr_nxt, 2'b00} +: 4];
        w_blank      = blank_lz & w_lz[w_ptr_nxt];
        w_number_nxt = (w_blank || w_blink) ? BLANK_CODE : w_digit;
    end

    // Scan pointer, display registers and the pending/shadow double buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr           <= '0;
            r_an            <= ptr_to_an(2'd0);
            r_number        <= 4'h0;
            r_shadow        <= 16'h0000;
            r_pending       <= 16'h0000;
            r_pending_valid <= 1'b0;
            r_load_ack      <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_an         <= ptr_to_an(w_ptr_nxt);
            r_number     <= w_number_nxt;
            r_shadow     <= w_shadow_nxt;
            r_load_ack   <= w_apply;
            r_frame_done <= w_wrap;
            if (load) begin
                // A load coinciding with an apply stays pending for the next frame.
                r_pending       <= digits_in;
                r_pending_valid <= 1'b1;
            end else if (w_apply) begin
                r_pending_valid <= 1'b0;
            end
        end
    end

    assign an         = r_an;
    assign number     = r_number;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan.sv
// Testbench for seg_scan with REFRESH_DIV=4, BLINK_FRAMES=2 (SEG_BLINK_EN aware).
module tb_seg_scan;

    localparam int unsigned DIV = 4;
    localparam int unsigned BF  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [3:0]  number;
    logic [3:0]  an;
    logic        load_ack;
    logic        frame_done;

    typedef struct {
        logic [3:0] an;
        logic [3:0] num;
    } exp_t;

    typedef struct {
        logic [15:0] digits;
        logic        blz;
        logic [15:0] nums;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[7];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_cnt  = 0;
    logic [15:0] cur;

    seg_scan #(
        .REFRESH_DIV  (DIV),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .number     (number),
        .an         (an),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (load_ack === 1'b1) ack_cnt++;
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 64 && frame_done !== 1'b1; i++) step(1);
        if (frame_done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_timeout: got no frame_done expected frame_done within 64 cycles");
        end
    endtask

    task automatic push_exp(input logic [15:0] nums);
        exp_t       e;
        logic [3:0] one;
        for (int k = 0; k < 4; k++) begin
            one   = 4'b0001;
            e.an  = ~(one << k);
            e.num = nums[k*4 +: 4];
            exp_q.push_back(e);
        end
    endtask

    // Starts at the first cycle of slot 0; ends at the first cycle of the next frame.
    task automatic check_frame(input string tag);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_queue: got empty expected entry", tag);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_an%0d", tag, k), 16'(an), 16'(e.an));
                chk($sformatf("%s_num%0d", tag, k), 16'(number), 16'(e.num));
                if (k > 0) chk($sformatf("%s_fd%0d", tag, k), 16'(frame_done), 16'h0);
            end
            step(DIV);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 16'h1234};
        vecs[1] = '{16'h0050, 1'b1, 16'hFF50};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0};
        vecs[3] = '{16'h0300, 1'b1, 16'hF300};
        vecs[4] = '{16'hABCF, 1'b0, 16'hABCF};
        vecs[5] = '{16'h0000, 1'b0, 16'h0000};
        vecs[6] = '{16'h0007, 1'b1, 16'hFFF7};

        rst_n      = 1'b0;
        digits_in  = 16'h0;
        load       = 1'b0;
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        #12;
        chk("rst_an", 16'(an), 16'h000E);
        chk("rst_num", 16'(number), 16'h0);
        chk("rst_ack", 16'(load_ack), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scanning after reset: zeros in every slot, 16-cycle frame period.
        wait_frame();
        push_exp(16'h0000);
        check_frame("idle");
        chk("frame_period", 16'(frame_done), 16'h1);
        cur = 16'h0000;

        // Table-driven loads: display holds until the wrap, then shows the new digits.
        foreach (vecs[v]) begin
            step(5);
            digits_in = vecs[v].digits;
            load      = 1'b1;
            step(1);
            load = 1'b0;
            push_exp(vecs[v].nums);
            step(2);
            chk($sformatf("v%0d_hold2", v), 16'(number), 16'(cur[11:8]));
            step(4);
            chk($sformatf("v%0d_hold3", v), 16'(number), 16'(cur[15:12]));
            ack_cnt = 0;
            wait_frame();
            chk($sformatf("v%0d_ack", v), 16'(load_ack), 16'h1);
            blank_lz = vecs[v].blz;
            check_frame($sformatf("v%0d", v));
            chk($sformatf("v%0d_single_ack", v), 16'(ack_cnt), 16'h1);
            cur = vecs[v].nums;
        end
        blank_lz = 1'b0;
        cur      = 16'h0007;

        // Two loads before one wrap: last one wins, one ack.
        step(5);
        digits_in = 16'h1111;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        digits_in = 16'h5678;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        push_exp(16'h5678);
        step(2);
        chk("dbl_hold3", 16'(number), 16'(cur[15:12]));
        ack_cnt = 0;
        wait_frame();
        chk("dbl_ack", 16'(load_ack), 16'h1);
        check_frame("dbl");
        chk("dbl_single_ack", 16'(ack_cnt), 16'h1);

        // Load in the wrap cycle: earlier pending applies now, new one at the following wrap.
        step(5);
        digits_in = 16'h2222;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        push_exp(16'h2222);
        ack_cnt = 0;
        step(9);
        digits_in = 16'h3333;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        push_exp(16'h3333);
        wait_frame();
        chk("wrap_ack_a", 16'(load_ack), 16'h1);
        check_frame("wrap_a");
        wait_frame();
        chk("wrap_ack_b", 16'(load_ack), 16'h1);
        check_frame("wrap_b");
        chk("wrap_two_acks", 16'(ack_cnt), 16'h2);

        // Reset with a pending load: discarded, no ack, scanning restarts at digit0.
        step(5);
        digits_in = 16'h4444;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_an", 16'(an), 16'h000E);
        chk("mrst_num", 16'(number), 16'h0);
        chk("mrst_ack", 16'(load_ack), 16'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        ack_cnt = 0;
        step(2);
        chk("mrst_restart_an", 16'(an), 16'h000E);
        wait_frame();
        chk("mrst_no_ack", 16'(load_ack), 16'h0);
        push_exp(16'h0000);
        check_frame("mrst");
        chk("mrst_ack_cnt", 16'(ack_cnt), 16'h0);

        // Blink on digit0 from a fresh reset so the phase is known.
        rst_n = 1'b0;
        step(2);
        rst_n      = 1'b1;
        blink_mask = 4'b0001;
        step(5);
        digits_in = 16'h9999;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        for (int f = 0; f < 6; f++) begin
`ifdef SEG_BLINK_EN
            if ((((f + 1) / 2) % 2) == 1) push_exp(16'h999F);
            else                          push_exp(16'h9999);
`else
            push_exp(16'h9999);
`endif
        end
        ack_cnt = 0;
        wait_frame();
        chk("blink_ack", 16'(load_ack), 16'h1);
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            check_frame($sformatf("blink_f%0d", f));
        end
        chk("blink_ack_cnt", 16'(ack_cnt), 16'h1);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
